// File: rtl/fetch_controller.sv
// RV32I instruction fetch sequencer: PC, single-outstanding imem request, decode handoff.
// Optional FETCH_PERF_CNT_EN adds fetched/stall/flush performance counters.
module fetch_controller #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] HALT_ADDR    = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_target_i,
   input  logic        halt_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic [31:0] instr_pc_plus_4_o,
   output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched_o,
   output logic [31:0] perf_stall_o,
   output logic [31:0] perf_flush_o
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DELIVER,
      HALTED
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] redir_pc;
   logic [31:0] new_pc;
   logic        load;
   logic        halt_take;
   logic        capture;
   logic        unused_tgt;

   assign imem_addr_o = pc;
   assign redir_pc    = {redirect_target_i[31:2], 2'b00};
   assign unused_tgt  = ^redirect_target_i[1:0];

   assign halt_take = (state == DELIVER) && halt_i && !stall_i;
   assign capture   = (state == FETCH) && imem_ready_i
                      && !redirect_valid_i;

   // load: a new fetch address is chosen this cycle
   always_comb begin
      load   = 1'b0;
      new_pc = pc;
      unique case (state)
         IDLE: begin
            load = 1'b1;
         end
         FETCH: begin
            if (redirect_valid_i) begin
               load   = 1'b1;
               new_pc = redir_pc;
            end
         end
         DELIVER: begin
            if (halt_take) begin
               load = 1'b0;
            end else if (redirect_valid_i) begin
               load   = 1'b1;
               new_pc = redir_pc;
            end else if (!stall_i) begin
               load   = 1'b1;
               new_pc = pc + 32'd4;
            end
         end
         default: begin
            load = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         pc                <= RESET_VECTOR;
         imem_req_o        <= 1'b0;
         instr_valid_o     <= 1'b0;
         halted_o          <= 1'b0;
         instr_o           <= NOP;
         instr_pc_o        <= RESET_VECTOR;
         instr_pc_plus_4_o <= RESET_VECTOR + 32'd4;
      end else begin
         unique case (1'b1)
            halt_take: begin
               state         <= HALTED;
               imem_req_o    <= 1'b0;
               instr_valid_o <= 1'b0;
               halted_o      <= 1'b1;
            end
            load: begin
               pc            <= new_pc;
               instr_valid_o <= 1'b0;
               // the halt address is caught before any request goes out
               if (new_pc == HALT_ADDR) begin
                  state      <= HALTED;
                  imem_req_o <= 1'b0;
                  halted_o   <= 1'b1;
               end else begin
                  state      <= FETCH;
                  imem_req_o <= 1'b1;
               end
            end
            capture: begin
               state             <= DELIVER;
               imem_req_o        <= 1'b0;
               instr_valid_o     <= 1'b1;
               instr_o           <= imem_rdata_i;
               instr_pc_o        <= pc;
               instr_pc_plus_4_o <= pc + 32'd4;
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic flush_take;

   assign flush_take = redirect_valid_i && !halt_take
                       && (state == FETCH || state == DELIVER);

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_o <= 32'd0;
         perf_stall_o   <= 32'd0;
         perf_flush_o   <= 32'd0;
      end else begin
         if (state == DELIVER && !stall_i)
            perf_fetched_o <= perf_fetched_o + 32'd1;
         if (state == DELIVER && stall_i)
            perf_stall_o <= perf_stall_o + 32'd1;
         if (flush_take)
            perf_flush_o <= perf_flush_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios then random
// traffic against a transaction-level reference model.
module tb_fetch_controller;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] HA = 32'h0000_004C;

   logic        clk;
   logic        reset;
   logic        stall_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_target_i;
   logic        halt_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic [31:0] instr_pc_plus_4_o;
   logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_o;
   logic [31:0] perf_stall_o;
   logic [31:0] perf_flush_o;
`endif

   fetch_controller #(
      .RESET_VECTOR(RV),
      .HALT_ADDR   (HA)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .stall_i          (stall_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_target_i(redirect_target_i),
      .halt_i           (halt_i),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_ready_i     (imem_ready_i),
      .imem_rdata_i     (imem_rdata_i),
      .instr_valid_o    (instr_valid_o),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o),
      .instr_pc_plus_4_o(instr_pc_plus_4_o),
      .halted_o         (halted_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o   (perf_fetched_o),
      .perf_stall_o     (perf_stall_o),
      .perf_flush_o     (perf_flush_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // Reference: a fetch is either starting, waiting on memory, holding a
   // word for decode, or stopped for good.
   bit          m_boot, m_wait, m_hold, m_stop;
   logic [31:0] m_pc, m_instr, m_ipc;
   int unsigned m_fet, m_stl, m_fls;

   function automatic void m_go(input logic [31:0] a);
      m_pc   = a;
      m_hold = 0;
      if (a == HA) begin
         m_stop = 1;
         m_wait = 0;
      end else begin
         m_wait = 1;
      end
   endfunction

   function automatic void m_step(input bit r, st, rv,
                                  input logic [31:0] rt,
                                  input bit h, rd);
      logic [31:0] tgt;
      tgt = rt & 32'hFFFF_FFFC;
      if (r) begin
         m_boot = 1; m_wait = 0; m_hold = 0; m_stop = 0;
         m_pc = RV; m_instr = 32'h13; m_ipc = RV;
         m_fet = 0; m_stl = 0; m_fls = 0;
      end else if (m_stop) begin
         return;
      end else if (m_boot) begin
         m_boot = 0;
         m_go(m_pc);
      end else if (m_wait) begin
         if (rv) begin
            m_fls++;
            m_go(tgt);
         end else if (rd) begin
            m_instr = mem(m_pc);
            m_ipc   = m_pc;
            m_wait  = 0;
            m_hold  = 1;
         end
      end else if (m_hold) begin
         if (st) m_stl++;
         else m_fet++;
         if (h && !st) begin
            m_hold = 0;
            m_stop = 1;
         end else if (rv) begin
            m_fls++;
            m_go(tgt);
         end else if (!st) begin
            m_go(m_pc + 32'd4);
         end
      end
   endfunction

   task automatic compare_all();
      check("req", imem_req_o, m_wait);
      check("addr", imem_addr_o, m_pc);
      check("valid", instr_valid_o, m_hold);
      check("instr", instr_o, m_instr);
      check("ipc", instr_pc_o, m_ipc);
      check("ipc4", instr_pc_plus_4_o, m_ipc + 32'd4);
      check("halted", halted_o, m_stop);
`ifdef FETCH_PERF_CNT_EN
      check("pf_fet", perf_fetched_o, m_fet);
      check("pf_stl", perf_stall_o, m_stl);
      check("pf_fls", perf_flush_o, m_fls);
`endif
   endtask

   task automatic tick(input bit r, st, rv, input logic [31:0] rt,
                       input bit h, rd);
      reset             = r;
      stall_i           = st;
      redirect_valid_i  = rv;
      redirect_target_i = rt;
      halt_i            = h;
      imem_ready_i      = rd;
      imem_rdata_i      = mem(imem_addr_o);
      m_step(r, st, rv, rt, h, rd);
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic [31:0] rnd_tgt();
      unique case ($urandom_range(0, 3))
         0: return 32'h100 + $urandom_range(0, 32'hFFF);
         1: return 32'h30 + $urandom_range(0, 32'h20);
         2: return 32'hFFFF_FFF0 + $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] last;
      int n;
      reset = 1; stall_i = 0; redirect_valid_i = 0;
      redirect_target_i = 0; halt_i = 0; imem_ready_i = 0;
      imem_rdata_i = 0;
      @(negedge clk);
      tick(1, 0, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 0, 1);
      check("rst_req", imem_req_o, 0);
      check("rst_instr", instr_o, 32'h13);
      check("rst_valid", instr_valid_o, 0);

      tick(0, 0, 0, 0, 0, 1);
      check("c1_req", imem_req_o, 1);
      check("c1_addr", imem_addr_o, 0);
      tick(0, 0, 0, 0, 0, 1);
      check("c2_valid", instr_valid_o, 1);
      check("c2_instr", instr_o, 32'h0050_0093);
      check("c2_pc4", instr_pc_plus_4_o, 4);
      tick(0, 0, 0, 0, 0, 1);
      check("c3_addr", imem_addr_o, 4);

      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 0, 0, 0);
         check("ws_req", imem_req_o, 1);
         check("ws_addr", imem_addr_o, 4);
      end
      tick(0, 0, 0, 0, 0, 1);
      check("ws_valid", instr_valid_o, 1);

      tick(0, 1, 0, 0, 0, 1);
      tick(0, 1, 0, 0, 0, 1);
      check("st_valid", instr_valid_o, 1);
      check("st_ipc", instr_pc_o, 4);
      tick(0, 0, 0, 0, 0, 1);
      check("st_addr", imem_addr_o, 8);

      tick(0, 0, 1, 32'h103, 0, 1);
      check("rf_valid", instr_valid_o, 0);
      check("rf_addr", imem_addr_o, 32'h100);
      tick(0, 0, 0, 0, 0, 1);
      tick(0, 1, 1, 32'h204, 0, 1);
      check("rd_valid", instr_valid_o, 0);
      check("rd_addr", imem_addr_o, 32'h204);

      tick(0, 0, 0, 0, 0, 1);
      tick(0, 0, 1, 32'h300, 1, 1);
      check("h_halted", halted_o, 1);
      for (int i = 0; i < 20; i++) begin
         tick(0, $urandom_range(0, 1), 1, rnd_tgt(), 1, 1);
         check("h_req", imem_req_o, 0);
      end

      tick(1, 0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 1);
      check("rs_addr", imem_addr_o, RV);
      check("rs_req", imem_req_o, 1);

      last = 32'hDEAD_BEEF;
      n = 0;
      while (!halted_o && n < 200) begin
         if (imem_req_o) last = imem_addr_o;
         tick(0, 0, 0, 0, 0, 1);
         n++;
      end
      check("ha_halted", halted_o, 1);
      check("ha_last", last, 32'h48);
`ifdef FETCH_PERF_CNT_EN
      check("ha_fetched", perf_fetched_o, 19);
`endif

      tick(1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4000; i++) begin
         bit r;
         r = ($urandom_range(0, 149) == 0) ||
             (m_stop && $urandom_range(0, 9) == 0);
         tick(r, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
              rnd_tgt(), $urandom_range(0, 39) == 0,
              $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
